// File: rtl/rr_issue_arbiter_pkg.sv
// rtl/rr_issue_arbiter_pkg.sv - shared constants and state encoding for the round-robin issue arbiter
package rr_issue_arbiter_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;
  localparam logic [IDX_W:0] GRANT_NONE = 5'd16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick16.sv
// rtl/rr_pick16.sv - combinational rotate-and-priority-pick of the first set request from a start pointer
module rr_pick16
  import rr_issue_arbiter_pkg::*;
#(
  parameter int DIRECTION = 0
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  // Walk 16 positions from ptr; the 4-bit candidate wraps naturally mod 16.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (DIRECTION != 0) ? ptr_i - IDX_W'(i) : ptr_i + IDX_W'(i);
      if (!any_o && req_i[cand]) begin
        any_o          = 1'b1;
        idx_o          = cand;
        onehot_o       = '0;
        onehot_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_issue_arbiter.sv
// rtl/rr_issue_arbiter.sv - 16-way round-robin issue arbiter with registered grant, stall hold and flush
module rr_issue_arbiter
  import rr_issue_arbiter_pkg::*;
#(
  parameter int DIRECTION = 0,
  parameter int N_REQ     = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_REQ-1:0] req,
  input  logic             flush,
  input  logic             fu_ready,
  output logic             grant_valid,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [IDX_W:0]   grant_idx,
  output logic [IDX_W-1:0] ptr
);

  generate
    if (N_REQ != 16) begin : g_bad_n_req
      $error("rr_issue_arbiter: N_REQ must be 16");
    end
  endgenerate

  localparam logic [IDX_W-1:0] PTR_RST = (DIRECTION != 0) ? 4'd15 : 4'd0;

  arb_state_e       state_q, state_d;
  logic [15:0]      onehot_q, onehot_d;
  logic [IDX_W:0]   idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             handshake;
  logic [IDX_W-1:0] ptr_adv;
  logic [IDX_W-1:0] pick_ptr;
  logic [15:0]      pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  assign handshake = (state_q == GRANT) && fu_ready;
  assign ptr_adv   = (DIRECTION != 0) ? idx_q[IDX_W-1:0] - 4'd1 : idx_q[IDX_W-1:0] + 4'd1;
  // A back-to-back grant must search from the pointer the handshake is about to install.
  assign pick_ptr  = handshake ? ptr_adv : ptr_q;

  rr_pick16 #(
    .DIRECTION(DIRECTION)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (pick_ptr),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    if (flush) begin
      state_d  = IDLE;
      onehot_d = '0;
      idx_d    = GRANT_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_d  = GRANT;
            onehot_d = pick_onehot;
            idx_d    = {1'b0, pick_idx};
          end
        end
        GRANT: begin
          if (fu_ready) begin
            ptr_d = ptr_adv;
            if (pick_any) begin
              onehot_d = pick_onehot;
              idx_d    = {1'b0, pick_idx};
            end else begin
              state_d  = IDLE;
              onehot_d = '0;
              idx_d    = GRANT_NONE;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          onehot_d = '0;
          idx_d    = GRANT_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      onehot_q <= '0;
      idx_q    <= GRANT_NONE;
      ptr_q    <= PTR_RST;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
    end
  end

  assign grant_valid  = (state_q == GRANT);
  assign grant_onehot = onehot_q;
  assign grant_idx    = idx_q;
  assign ptr          = ptr_q;

endmodule
